mult_dispatch: RTL and testbench
================================

MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width, matching the downstream Multiplier.
REQ-002 SHALL have parameter DEPTH, default 4: operand FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 2*WIDTH+4: maximum WAIT cycles before abort.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  operand pair accepted when high with in_valid.
REQ-008 SHALL have port in_multiplier  input  WIDTH  secret operand.
REQ-009 SHALL have port in_multiplicand  input  WIDTH  public operand.
REQ-010 SHALL have port start  output  1  one-cycle launch pulse to the Multiplier.
REQ-011 SHALL have port multiplier  output  WIDTH  registered operand to the Multiplier.
REQ-012 SHALL have port multiplicand  output  WIDTH  registered operand to the Multiplier.
REQ-013 SHALL have port product  input  2*WIDTH  Multiplier result.
REQ-014 SHALL have port productDone  input  1  Multiplier completion flag.
REQ-015 SHALL have port out_valid  output  1  result available.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port out_product  output  2*WIDTH  captured product.
REQ-018 SHALL have port out_timeout  output  1  result was aborted by timeout.
REQ-019 SHALL have port count  output  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-020 SHALL accept a pair on any rising edge where in_valid && in_ready; in_ready = (count < DEPTH), with no same-cycle bypass from a pop.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop, and SHALL never overflow or underflow; pointers wrap modulo DEPTH.
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-023 IDLE SHALL go to ISSUE when count != 0 and stay in IDLE otherwise.
REQ-024 ISSUE SHALL last exactly one cycle: start=1, multiplier/multiplicand loaded from the FIFO head, head popped, then go to WAIT.
REQ-025 SHALL hold multiplier/multiplicand stable from ISSUE until leaving WAIT; start SHALL be 0 in every other state.
REQ-026 WAIT SHALL ignore productDone in its first cycle (guard against a stale flag) and SHALL otherwise count cycles from 1.
REQ-027 WAIT SHALL, on productDone=1 after the guard cycle, capture product into out_product, clear out_timeout, and go to HOLD.
REQ-028 WAIT SHALL, when the cycle counter reaches TIMEOUT without productDone, set out_product=0 and out_timeout=1, and go to HOLD.
REQ-029 productDone wins if it and the timeout occur in the same cycle.
REQ-030 HOLD SHALL assert out_valid with out_product/out_timeout stable, and go to IDLE on out_valid && out_ready.
REQ-031 Latency: a pair accepted in cycle N into an empty, IDLE block SHALL produce start=1 in cycle N+2; out_valid SHALL rise the cycle after productDone is sampled.
REQ-032 SHALL keep accepting pushes in every state while not full.

Reset
REQ-033 SHALL, on rst=1 (asynchronous), force state=IDLE, FIFO empty, count=0, start=0, multiplier=0, multiplicand=0, out_valid=0, out_product=0, out_timeout=0, and clear the WAIT counter.
REQ-034 SHALL, on reset during WAIT or HOLD, discard the in-flight operation with no result emitted.
REQ-035 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-036 SHALL take the FSM state enum and the default WIDTH/DEPTH constants from shared package mult_pkg.
REQ-037 SHALL implement the operand FIFO as sub-module mult_operand_fifo (push/pop/count, 2*WIDTH-bit entries).

Verification (WIDTH=4, DEPTH=4, TIMEOUT=12, behavioural Multiplier raising productDone 6 cycles after start)
REQ-038 SHALL check: push 3x5 -> start high in cycle N+2 with multiplier=3 and multiplicand=5; out_product=15, out_timeout=0.
REQ-039 SHALL check: out_ready=0, push 6 pairs -> in_ready=0 after the 4th accepted pair, count=4, 5th pair held until a pop.
REQ-040 SHALL check: productDone tied 0 -> out_timeout=1 and out_product=0 after 12 WAIT cycles, then the next queued pair issues.
REQ-041 SHALL check: rst pulsed mid-WAIT -> all outputs at reset values, count=0, no out_valid afterwards.
REQ-042 SHALL check: 15x15 with out_ready low 5 cycles -> out_product=225 held stable, one handshake only.
REQ-043 SHALL check: push and ISSUE pop in the same cycle with count=2 -> count stays 2, order preserved.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier dispatch block and its
// operand FIFO.
package mult_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Shift-add multiplier needs about two cycles per bit plus setup.
    function automatic int timeout_default(input int width);
        return 2 * width + 4;
    endfunction

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO: power-of-two depth, registered occupancy, full flag
// taken from the registered count so a pop never frees a slot the same cycle.
module mult_operand_fifo
    import mult_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mult_dispatch.sv
// Dispatcher that queues operand pairs and drives one external Multiplier at a
// time, with a stale-flag guard, a completion timeout and a held result.
module mult_dispatch
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = timeout_default(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_multiplier,
    input  logic [WIDTH-1:0]           in_multiplicand,
    output logic                       start,
    output logic [WIDTH-1:0]           multiplier,
    output logic [WIDTH-1:0]           multiplicand,
    input  logic [2*WIDTH-1:0]         product,
    input  logic                       productDone,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_product,
    output logic                       out_timeout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] GUARD_C   = WCNT_W'(1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WCNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [2*WIDTH-1:0]   out_product_q, out_product_d;
    logic                 out_timeout_q, out_timeout_d;
    logic                 fifo_pop, fifo_full;
    logic [2*WIDTH-1:0]   fifo_head;

    mult_operand_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .data_i  ({in_multiplier, in_multiplicand}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (count),
        .full_o  (fifo_full)
    );

    assign in_ready     = !fifo_full;
    assign start        = (state_q == ST_ISSUE);
    assign out_valid    = (state_q == ST_HOLD);
    assign multiplier   = mult_q;
    assign multiplicand = mcand_q;
    assign out_product  = out_product_q;
    assign out_timeout  = out_timeout_q;

    always_comb begin
        state_d       = state_q;
        mult_d        = mult_q;
        mcand_d       = mcand_q;
        wait_cnt_d    = wait_cnt_q;
        out_product_d = out_product_q;
        out_timeout_d = out_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Operands are latched on entry so they are valid alongside start.
                if (count != '0) begin
                    state_d = ST_ISSUE;
                    mult_d  = fifo_head[2*WIDTH-1:WIDTH];
                    mcand_d = fifo_head[WIDTH-1:0];
                end
            end
            ST_ISSUE: begin
                fifo_pop   = 1'b1;
                wait_cnt_d = GUARD_C;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (productDone && (wait_cnt_q != GUARD_C)) begin
                    out_product_d = product;
                    out_timeout_d = 1'b0;
                    wait_cnt_d    = '0;
                    state_d       = ST_HOLD;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    out_product_d = '0;
                    out_timeout_d = 1'b1;
                    wait_cnt_d    = '0;
                    state_d       = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mult_q        <= '0;
            mcand_q       <= '0;
            wait_cnt_q    <= '0;
            out_product_q <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mult_q        <= mult_d;
            mcand_q       <= mcand_d;
            wait_cnt_q    <= wait_cnt_d;
            out_product_q <= out_product_d;
            out_timeout_q <= out_timeout_d;
        end
    end

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch with a behavioural Multiplier that raises
// productDone six cycles after start.
module tb_mult_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_multiplier, in_multiplicand;
    logic       start;
    logic [3:0] multiplier, multiplicand;
    logic [7:0] product;
    logic       productDone;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic       out_timeout;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    logic [3:0] m_cnt;
    logic [7:0] m_prod;
    logic       done_en;

    always #5 clk = ~clk;

    mult_dispatch dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplier   (in_multiplier),
        .in_multiplicand (in_multiplicand),
        .start           (start),
        .multiplier      (multiplier),
        .multiplicand    (multiplicand),
        .product         (product),
        .productDone     (productDone),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_product     (out_product),
        .out_timeout     (out_timeout),
        .count           (count)
    );

    // Behavioural Multiplier: productDone high in the sixth cycle after start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= '0;
            m_prod <= '0;
        end else if (start) begin
            m_cnt  <= 4'd1;
            m_prod <= multiplier * multiplicand;
        end else if (m_cnt == 4'd6) begin
            m_cnt <= '0;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt + 4'd1;
        end
    end

    assign product     = m_prod;
    assign productDone = done_en && (m_cnt == 4'd6);

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] a, input logic [3:0] b);
        int n;
        in_valid        = 1'b1;
        in_multiplier   = a;
        in_multiplicand = b;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check(tag, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!start && n < 60) begin
            tick();
            n++;
        end
        check(tag, start, 1);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] prod, input logic to);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_prod"}, out_product, prod);
        check({tag, "_to"}, out_timeout, to);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_mplier"}, multiplier, 0);
        check({tag, "_mcand"}, multiplicand, 0);
        check({tag, "_ovalid"}, out_valid, 0);
        check({tag, "_oprod"}, out_product, 0);
        check({tag, "_oto"}, out_timeout, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_inrdy"}, in_ready, 1);
    endtask

    initial begin
        int n;
        int hs0;
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_multiplier   = '0;
        in_multiplicand = '0;
        out_ready       = 1'b0;
        done_en         = 1'b1;

        // Reset state, then basic 3x5 with exact latency.
        repeat (2) @(posedge clk);
        #1;
        check("rst_inrdy_during", in_ready, 1);
        rst = 1'b0;
        check_reset_outputs("rst0");
        tick();
        in_valid        = 1'b1;
        in_multiplier   = 4'd3;
        in_multiplicand = 4'd5;
        tick();
        in_valid = 1'b0;
        check("t1_count_n1", count, 1);
        check("t1_start_n1", start, 0);
        tick();
        check("t1_start_n2", start, 1);
        check("t1_mplier", multiplier, 3);
        check("t1_mcand", multiplicand, 5);
        repeat (3) tick();
        check("t1_start_low", start, 0);
        check("t1_mplier_hold", multiplier, 3);
        repeat (3) tick();
        check("t1_ovalid_s6", out_valid, 0);
        tick();
        check("t1_ovalid_s7", out_valid, 1);
        expect_result("t1", 8'd15, 1'b0);
        check("t1_ovalid_after", out_valid, 0);

        // Fill the FIFO behind a stalled result; sixth pair waits for a pop.
        push("t2_p0", 4'd1, 4'd1);
        push("t2_p1", 4'd1, 4'd2);
        push("t2_p2", 4'd2, 4'd2);
        push("t2_p3", 4'd2, 4'd3);
        push("t2_p4", 4'd3, 4'd3);
        check("t2_full_count", count, 4);
        check("t2_full_inrdy", in_ready, 0);
        in_valid        = 1'b1;
        in_multiplier   = 4'd1;
        in_multiplicand = 4'd4;
        repeat (3) tick();
        check("t2_held_inrdy", in_ready, 0);
        check("t2_held_count", count, 4);
        expect_result("t2_r0", 8'd1, 1'b0);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("t2_p5_acc", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t2_refill_count", count, 4);
        expect_result("t2_r1", 8'd2, 1'b0);
        expect_result("t2_r2", 8'd4, 1'b0);
        expect_result("t2_r3", 8'd6, 1'b0);
        expect_result("t2_r4", 8'd9, 1'b0);
        expect_result("t2_r5", 8'd4, 1'b0);

        // Timeout: no productDone, abort after exactly 12 WAIT cycles.
        done_en = 1'b0;
        push("t3_p0", 4'd7, 4'd2);
        push("t3_p1", 4'd2, 4'd2);
        wait_start("t3_start");
        check("t3_mplier", multiplier, 7);
        repeat (12) tick();
        check("t3_ovalid_w12", out_valid, 0);
        tick();
        check("t3_ovalid_w13", out_valid, 1);
        done_en = 1'b1;
        expect_result("t3_r0", 8'd0, 1'b1);
        wait_start("t3_next_start");
        check("t3_next_mplier", multiplier, 2);
        expect_result("t3_r1", 8'd4, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        push("t4_p0", 4'd5, 4'd5);
        push("t4_p1", 4'd6, 4'd6);
        wait_start("t4_start");
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t4_rst");
        tick();
        rst = 1'b0;
        check("t4_inrdy_after", in_ready, 1);
        check("t4_count_after", count, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || start) n++;
            tick();
        end
        check("t4_no_activity", n, 0);

        // 15x15 held under backpressure, single handshake.
        push("t5_p0", 4'd15, 4'd15);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("t5_valid", out_valid, 1);
        check("t5_prod", out_product, 225);
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold", {out_valid, out_timeout, out_product}, {1'b1, 1'b0, 8'd225});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_hs_once", hs_cnt - hs0, 1);
        repeat (3) tick();
        check("t5_valid_gone", out_valid, 0);
        check("t5_hs_still_once", hs_cnt - hs0, 1);

        // Push coinciding with the ISSUE pop at count=2.
        push("t6_a", 4'd1, 4'd3);
        push("t6_b", 4'd2, 4'd3);
        push("t6_c", 4'd3, 4'd3);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("t6_pre_count", count, 2);
        expect_result("t6_ra", 8'd3, 1'b0);
        tick();
        check("t6_issue", start, 1);
        check("t6_issue_count", count, 2);
        in_valid        = 1'b1;
        in_multiplier   = 4'd2;
        in_multiplicand = 4'd7;
        tick();
        in_valid = 1'b0;
        check("t6_count_kept", count, 2);
        expect_result("t6_rb", 8'd6, 1'b0);
        expect_result("t6_rc", 8'd9, 1'b0);
        expect_result("t6_rd", 8'd14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
